// File: rtl/pa_noc.sv
// rtl/pa_noc.sv - shared NoC constants, port indices and arbiter state encoding
package pa_noc;

  localparam int NUM_ROUTER_PORTS = 5;
  localparam int APB_PACKET_WIDTH = 32;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_EAST  = 3'd3,
    PORT_WEST  = 3'd4
  } port_idx_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rtl/rr_arbiter_pick.sv - combinational round-robin pick starting after the pointer
module rr_arbiter_pick #(
  parameter int N_REQ = 5,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] cand;

  // Scan offsets 1..N_REQ so the last granted requester has lowest priority.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    if (en_i) begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = IW'((int'(ptr_i) + k) % N_REQ);
        if (!any_o && req_i[cand]) begin
          any_o       = 1'b1;
          gnt_o[cand] = 1'b1;
          idx_o       = cand;
        end
      end
    end
  end

endmodule

// File: rtl/router_output_arbiter.sv
// rtl/router_output_arbiter.sv - round-robin share of one router output link
module router_output_arbiter
  import pa_noc::*;
#(
  parameter int N_REQ        = NUM_ROUTER_PORTS,
  parameter int PACKET_WIDTH = APB_PACKET_WIDTH,
  parameter int IW           = $clog2(N_REQ)
) (
  input  logic                                i_clk,
  input  logic                                i_srst,
  input  logic [N_REQ-1:0]                    i_reqValid,
  input  logic [N_REQ-1:0][PACKET_WIDTH-1:0]  i_reqPacket,
  output logic [N_REQ-1:0]                    o_reqReady,
  output logic                                o_valid,
  output logic [PACKET_WIDTH-1:0]             o_packet,
  output logic [IW-1:0]                       o_grantIdx,
  input  logic                                i_ready
);

  arb_state_e              state_q, state_d;
  logic [PACKET_WIDTH-1:0] packet_q, packet_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [IW-1:0]           ptr_q, ptr_d;

  logic                    slot_free;
  logic [N_REQ-1:0]        gnt;
  logic [IW-1:0]           gnt_idx;
  logic                    any_gnt;

  // Draining and loading in the same cycle keeps back-to-back throughput.
  assign slot_free = (state_q == ST_EMPTY) || i_ready;

  rr_arbiter_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i (i_reqValid),
    .ptr_i (ptr_q),
    .en_i  (slot_free && !i_srst),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (any_gnt)
  );

  always_comb begin
    state_d  = state_q;
    packet_d = packet_q;
    idx_d    = idx_q;
    ptr_d    = ptr_q;
    if (any_gnt) begin
      state_d  = ST_FULL;
      packet_d = i_reqPacket[gnt_idx];
      idx_d    = gnt_idx;
      ptr_d    = gnt_idx;
    end else if (state_q == ST_FULL && i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q  <= ST_EMPTY;
      packet_q <= '0;
      idx_q    <= '0;
      ptr_q    <= IW'(N_REQ - 1);
    end else begin
      state_q  <= state_d;
      packet_q <= packet_d;
      idx_q    <= idx_d;
      ptr_q    <= ptr_d;
    end
  end

  assign o_reqReady = gnt;
  assign o_valid    = (state_q == ST_FULL);
  assign o_packet   = packet_q;
  assign o_grantIdx = idx_q;

endmodule

// File: tb/tb_router_output_arbiter.sv
// tb/tb_router_output_arbiter.sv - table-driven bench for router_output_arbiter
module tb_router_output_arbiter;

  localparam int N  = 5;
  localparam int PW = 32;

  logic              clk = 1'b0;
  logic              srst;
  logic [N-1:0]      req_valid;
  logic [N-1:0][PW-1:0] req_packet;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [PW-1:0]     out_packet;
  logic [2:0]        grant_idx;
  logic              ready;

  always #5 clk = ~clk;

  router_output_arbiter #(.N_REQ(N), .PACKET_WIDTH(PW)) dut (
    .i_clk       (clk),
    .i_srst      (srst),
    .i_reqValid  (req_valid),
    .i_reqPacket (req_packet),
    .o_reqReady  (req_ready),
    .o_valid     (out_valid),
    .o_packet    (out_packet),
    .o_grantIdx  (grant_idx),
    .i_ready     (ready)
  );

  typedef struct packed {
    logic            srst;
    logic [4:0]      vld;
    logic [4:0][7:0] pkt;
    logic            rdy;
    logic [4:0]      e_rr;
    logic            e_v;
    logic [7:0]      e_pkt;
    logic [2:0]      e_idx;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input logic s, input logic [4:0] vl, input logic [4:0][7:0] pk,
                              input logic r, input logic [4:0] err, input logic ev,
                              input logic [7:0] ep, input logic [2:0] ei);
    vec_t v;
    v.srst = s; v.vld = vl; v.pkt = pk; v.rdy = r;
    v.e_rr = err; v.e_v = ev; v.e_pkt = ep; v.e_idx = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    srst      = v.srst;
    req_valid = v.vld;
    ready     = v.rdy;
    for (int i = 0; i < N; i++) req_packet[i] = {24'h0, v.pkt[i]};
  endtask

  initial begin
    logic [4:0][7:0] pi, ap, z;
    int mptr;
    int waits[N];
    int max_wait;
    logic r;
    logic [4:0] exp_rr;

    pi = {8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
    ap = {8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0};
    z  = '0;

    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 5'h1F, pi, 1, 5'h00, 0, 8'h00, 3'd0));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(0, 5'h1F, pi, 1, 5'(1 << (k % 5)), 1, 8'(k % 5), 3'(k % 5)));
    vecs.push_back(mk(0, 5'b01000, {8'h00, 8'h3C, 8'h00, 8'h00, 8'h00}, 1, 5'b01000, 1, 8'h3C, 3'd3));
    vecs.push_back(mk(0, 5'b00000, z, 1, 5'b00000, 0, 8'h00, 3'd0));
    vecs.push_back(mk(0, 5'b00000, z, 0, 5'b00000, 0, 8'h00, 3'd0));
    vecs.push_back(mk(0, 5'b00010, {8'h00, 8'h00, 8'h00, 8'h11, 8'h00}, 0, 5'b00010, 1, 8'h11, 3'd1));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(0, 5'b10010, {8'h77, 8'h00, 8'h00, 8'h66, 8'h00}, 0, 5'b00000, 1, 8'h11, 3'd1));
    vecs.push_back(mk(0, 5'b10010, {8'h77, 8'h00, 8'h00, 8'h66, 8'h00}, 1, 5'b10000, 1, 8'h77, 3'd4));
    vecs.push_back(mk(0, 5'b00010, {8'h00, 8'h00, 8'h00, 8'h66, 8'h00}, 1, 5'b00010, 1, 8'h66, 3'd1));
    vecs.push_back(mk(0, 5'b00100, {8'h00, 8'h00, 8'h22, 8'h00, 8'h00}, 1, 5'b00100, 1, 8'h22, 3'd2));
    vecs.push_back(mk(0, 5'b00100, {8'h00, 8'h00, 8'h55, 8'h00, 8'h00}, 1, 5'b00100, 1, 8'h55, 3'd2));
    vecs.push_back(mk(0, 5'b00000, z, 0, 5'b00000, 1, 8'h55, 3'd2));
    vecs.push_back(mk(1, 5'h1F, ap, 1, 5'b00000, 0, 8'h00, 3'd0));
    vecs.push_back(mk(0, 5'h1F, ap, 1, 5'b00001, 1, 8'hA0, 3'd0));

    drive(vecs[0]);
    @(negedge clk);
    foreach (vecs[n]) begin
      drive(vecs[n]);
      #1;
      chk($sformatf("v%0d_reqReady", n), 32'(req_ready), 32'(vecs[n].e_rr));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", n), 32'(out_valid), 32'(vecs[n].e_v));
      if (vecs[n].e_v || vecs[n].srst) begin
        chk($sformatf("v%0d_packet", n), out_packet, {24'h0, vecs[n].e_pkt});
        chk($sformatf("v%0d_grantIdx", n), 32'(grant_idx), 32'(vecs[n].e_idx));
      end
    end

    // All requesters stay valid while downstream randomly stalls; grants must
    // rotate strictly and nobody waits N accepts.
    mptr = 0;
    max_wait = 0;
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int c = 0; c < 40; c++) begin
      r = 1'($urandom_range(0, 1));
      srst = 1'b0; req_valid = 5'h1F; ready = r;
      for (int i = 0; i < N; i++) req_packet[i] = {24'h0, ap[i]};
      #1;
      exp_rr = r ? 5'(1 << ((mptr + 1) % N)) : 5'b0;
      chk($sformatf("fair%0d_reqReady", c), 32'(req_ready), 32'(exp_rr));
      if (r) begin
        mptr = (mptr + 1) % N;
        for (int i = 0; i < N; i++) begin
          if (i == mptr) waits[i] = 0;
          else begin
            waits[i]++;
            if (waits[i] > max_wait) max_wait = waits[i];
          end
        end
      end
      @(posedge clk);
      #1;
      chk($sformatf("fair%0d_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("fair%0d_grantIdx", c), 32'(grant_idx), 32'(mptr));
    end
    chk("fair_max_wait_lt_N", 32'(max_wait < N), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
